serial_frame_receiver: RTL and testbench
========================================

// Module: serial_frame_receiver
// PURPOSE
//  Receive end of the serial bit stream that the serial emulator/modulator side drives (one bit per sampled CLK, LSB first).
//  Hunts for a sync word, verifies frame alignment, then deserializes payload words to parallel with a valid strobe.
//  Sits between the QPSK demapper/serial source and the byte-level consumer; reports lock status and sync errors.
// PARAMETERS
//  WIDTH          8            bits per word (sync and payload)
//  SYNC_WORD      8'b01111000  sync pattern, compared after LSB-first shift-in
//  PAYLOAD_WORDS  1            payload words following each sync word in a frame (0 allowed: no payload)
//  LOCK_COUNT     3            consecutive sync matches (including the HUNT match) required to lock, >=1
//  MISS_LIMIT     2            consecutive sync misses while locked that drop lock, >=1
// PORTS
//  CLK        in   1      clock, all state on rising edge
//  RST        in   1      asynchronous, active-high reset
//  Din        in   1      serial data bit
//  bit_en     in   1      Din sampled only when 1; bit_en=0 freezes all state
//  dout       out  WIDTH  payload word, held until next payload word
//  dout_valid out  1      one-cycle pulse per payload word
//  locked     out  1      1 while in LOCKED
//  sync_err   out  1      one-cycle pulse on each sync-slot mismatch (VERIFY or LOCKED)
//  inverted   out  1      stream polarity latched at HUNT match (0 without POLARITY_DETECT_EN)
// BEHAVIOUR
//  Reset (async): state=HUNT, shift reg=0, all counters=0, dout=0, dout_valid=0, locked=0, sync_err=0, inverted=0.
//  Shift: on sampled bit, sr_next = {Din, sr[WIDTH-1:1]}; all decisions use sr_next on the same edge.
//  Outputs registered: dout/dout_valid/sync_err/locked update on the edge sampling the word's last bit.
//  HUNT: compare sr_next every sampled bit; match -> bit_cnt=0, word_idx=1 (sync slot done), match_cnt=1;
//    next state LOCKED if LOCK_COUNT==1 else VERIFY. No sync_err in HUNT.
//  Frame: word_idx 0 = sync slot, 1..PAYLOAD_WORDS = payload; wraps after PAYLOAD_WORDS.
//  bit_cnt counts 0..WIDTH-1; word boundary when bit_cnt==WIDTH-1 (then bit_cnt->0, word_idx advances/wraps).
//  VERIFY: payload words discarded (no dout_valid). Sync slot match -> match_cnt++; reaching LOCK_COUNT -> LOCKED,
//    miss_cnt=0. Sync slot mismatch -> sync_err pulse, HUNT, match_cnt=0.
//  LOCKED: payload word -> dout=sr_next, dout_valid=1. Sync slot match -> miss_cnt=0.
//    Mismatch -> sync_err pulse, miss_cnt++; miss_cnt reaching MISS_LIMIT -> HUNT, locked=0 on same edge.
//  Transition back to HUNT: the word just shifted is not re-hunted; hunting resumes from the next sampled bit.
//  PAYLOAD_WORDS=0: every word is a sync slot; dout_valid never asserts.
//  Counter widths: bit_cnt clog2(WIDTH), word_idx clog2(PAYLOAD_WORDS+1) (min 1), match/miss saturate at limit.
//  Reset mid-frame: immediate return to reset values regardless of bit_en/state.
// CONFIGURATION
//  POLARITY_DETECT_EN defined: HUNT also accepts ~SYNC_WORD (resolves QPSK 180-deg ambiguity); inverted latched
//    to 1 on that match, 0 on true match; later sync slots compared against the latched polarity; dout = sr_next
//    XOR {WIDTH{inverted}}; inverted cleared on return to HUNT.
//  Not defined: only SYNC_WORD matches; inverted tied 0; no data inversion.
// TESTING
//  1 Repeating 8'h78 LSB-first, bit_en=1, defaults -> HUNT match at aligned word, locked=1 32 bits later,
//    then dout_valid every 16 bits with dout=8'h78, sync_err never pulses.
//  2 Din=0 constant for 200 cycles -> locked=0, dout_valid=0, sync_err=0 throughout.
//  3 Locked, one bit flipped in one sync slot -> single sync_err pulse, locked stays 1; two consecutive
//    corrupted sync slots -> locked falls on edge sampling last bit of second slot, state HUNT.
//  4 Test 1 stream with bit_en toggling 1/0 -> identical outputs per sampled bit; no state change when bit_en=0.
//  5 RST pulsed mid-payload while locked -> all outputs 0 asynchronously; relock after HUNT match + 32 bits.
//  6 Stream of 8'h87 (inverted sync) -> with POLARITY_DETECT_EN: locked=1, inverted=1, dout=8'h78;
//    without: locked stays 0.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receives a serial bit stream (one bit per enabled CLK, LSB first), hunts for a sync word,
//   confirms frame alignment over several frames, then deserializes the payload words.
//
//   Ports:
//     CLK        in   clock, rising edge
//     RST        in   asynchronous active-high reset
//     Din        in   serial data bit
//     bit_en     in   Din sampled only when 1; 0 freezes all state
//     dout       out  payload word, held until the next payload word
//     dout_valid out  one-cycle pulse per delivered payload word
//     locked     out  1 while frame lock is held
//     sync_err   out  one-cycle pulse on each sync-slot mismatch after the hunt match
//     inverted   out  stream polarity latched at the hunt match
//
//   Build option: define POLARITY_DETECT_EN to also accept the inverted sync word while hunting
//   and to un-invert payload data accordingly. Without it, inverted is tied 0.
module serial_frame_receiver #(
  parameter int unsigned       WIDTH         = 8,
  parameter logic [WIDTH-1:0]  SYNC_WORD     = 8'b01111000,
  parameter int unsigned       PAYLOAD_WORDS = 1,
  parameter int unsigned       LOCK_COUNT    = 3,
  parameter int unsigned       MISS_LIMIT    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Din,
  input  logic             bit_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             locked,
  output logic             sync_err,
  output logic             inverted
);

  localparam int unsigned BitCntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned WordIdxW = (PAYLOAD_WORDS > 0) ? $clog2(PAYLOAD_WORDS + 1) : 1;
  localparam int unsigned MatchW   = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int unsigned MissW    = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sr_q, sr_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WordIdxW-1:0] word_idx_q, word_idx_d;
  logic [MatchW-1:0]   match_cnt_q, match_cnt_d;
  logic [MissW-1:0]    miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                sync_err_q, sync_err_d;
  logic                inverted_q, inverted_d;

  logic [WIDTH-1:0]    sr_next;
  logic [WIDTH-1:0]    sync_exp;
  logic                hunt_true, hunt_inv, sync_hit, last_bit, word_wrap;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StHunt;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      word_idx_q   <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      inverted_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      word_idx_q   <= word_idx_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      inverted_q   <= inverted_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    dout_d       = dout_q;
    inverted_d   = inverted_q;
    // Strobes last a single clock even if bit_en drops afterwards
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;

    sr_next   = {Din, sr_q[WIDTH-1:1]};
    sync_exp  = SYNC_WORD ^ {WIDTH{inverted_q}};
    hunt_true = (sr_next == SYNC_WORD);
`ifdef POLARITY_DETECT_EN
    hunt_inv  = (sr_next == ~SYNC_WORD);
`else
    hunt_inv  = 1'b0;
`endif
    sync_hit  = (sr_next == sync_exp);
    last_bit  = (bit_cnt_q == BitCntW'(WIDTH - 1));
    word_wrap = (word_idx_q == WordIdxW'(PAYLOAD_WORDS));

    if (bit_en) begin
      sr_d = sr_next;
      unique case (state_q)
        StHunt: begin
          if (hunt_true || hunt_inv) begin
            inverted_d  = hunt_inv;
            bit_cnt_d   = '0;
            // The hunted word was the sync slot; with no payload the next word is sync again
            word_idx_d  = (PAYLOAD_WORDS == 0) ? '0 : WordIdxW'(1);
            match_cnt_d = MatchW'(1);
            miss_cnt_d  = '0;
            state_d     = (LOCK_COUNT == 1) ? StLocked : StVerify;
          end
        end
        StVerify, StLocked: begin
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end else begin
            bit_cnt_d  = '0;
            word_idx_d = word_wrap ? '0 : word_idx_q + WordIdxW'(1);
            if (word_idx_q != '0) begin
              // Payload slot: only delivered once locked
              if (state_q == StLocked) begin
                dout_d       = sr_next ^ {WIDTH{inverted_q}};
                dout_valid_d = 1'b1;
              end
            end else if (sync_hit) begin
              if (state_q == StVerify) begin
                if (int'(match_cnt_q) + 1 >= int'(LOCK_COUNT)) begin
                  match_cnt_d = MatchW'(LOCK_COUNT);
                  miss_cnt_d  = '0;
                  state_d     = StLocked;
                end else begin
                  match_cnt_d = match_cnt_q + MatchW'(1);
                end
              end else begin
                miss_cnt_d = '0;
              end
            end else begin
              sync_err_d = 1'b1;
              if ((state_q == StVerify) || (int'(miss_cnt_q) + 1 >= int'(MISS_LIMIT))) begin
                // Drop back to hunting; the current window is not re-examined
                state_d     = StHunt;
                match_cnt_d = '0;
                miss_cnt_d  = '0;
                bit_cnt_d   = '0;
                word_idx_d  = '0;
                inverted_d  = 1'b0;
              end else begin
                miss_cnt_d = miss_cnt_q + MissW'(1);
              end
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // Outputs
  always_comb begin
    locked     = (state_q == StLocked);
    dout       = dout_q;
    dout_valid = dout_valid_q;
    sync_err   = sync_err_q;
    inverted   = inverted_q;
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
//   Drives randomized and directed bit streams into serial_frame_receiver and compares every
//   output after every clock against a frame-level reference model (sliding window of the
//   most recent bits plus a bit-position counter since the hunt match).
module tb_serial_frame_receiver;

  localparam int unsigned W     = 8;
  localparam logic [7:0]  SYNC  = 8'h78;
  localparam int unsigned P     = 1;
  localparam int unsigned LOCK  = 3;
  localparam int unsigned MISS  = 2;
`ifdef POLARITY_DETECT_EN
  localparam bit PolEn = 1'b1;
`else
  localparam bit PolEn = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       Din;
  logic       bit_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       locked;
  logic       sync_err;
  logic       inverted;

  serial_frame_receiver #(
    .WIDTH        (W),
    .SYNC_WORD    (SYNC),
    .PAYLOAD_WORDS(P),
    .LOCK_COUNT   (LOCK),
    .MISS_LIMIT   (MISS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Din       (Din),
    .bit_en    (bit_en),
    .dout      (dout),
    .dout_valid(dout_valid),
    .locked    (locked),
    .sync_err  (sync_err),
    .inverted  (inverted)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic       win[$];
  bit         m_hunt, m_locked, m_inv, m_valid, m_err;
  logic [7:0] m_dout;
  int         m_pos, m_good, m_bad;

  // Bench-side observation counters
  int n_bits, lock_bit, n_valid, n_err, n_lock_cyc;

  task automatic model_reset();
    win.delete();
    repeat (W) win.push_back(1'b0);
    m_hunt = 1'b1; m_locked = 1'b0; m_inv = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    m_dout = '0; m_pos = 0; m_good = 0; m_bad = 0;
    n_bits = 0; lock_bit = -1; n_valid = 0; n_err = 0; n_lock_cyc = 0;
  endtask

  task automatic model_drop();
    m_hunt = 1'b1; m_locked = 1'b0; m_inv = 1'b0; m_good = 0; m_bad = 0;
  endtask

  task automatic model_bit(input logic d);
    logic [7:0] w;
    int slot;
    m_valid = 1'b0;
    m_err   = 1'b0;
    win.push_back(d);
    void'(win.pop_front());
    for (int i = 0; i < int'(W); i++) w[i] = win[i];
    if (m_hunt) begin
      if (w == SYNC || (PolEn && w == ~SYNC)) begin
        m_inv    = (w != SYNC);
        m_hunt   = 1'b0;
        m_pos    = 0;
        m_good   = 1;
        m_bad    = 0;
        m_locked = (LOCK == 1);
      end
    end else begin
      m_pos++;
      if (m_pos % int'(W) == 0) begin
        slot = (m_pos / int'(W)) % int'(P + 1);
        if (slot != 0) begin
          if (m_locked) begin
            m_dout  = w ^ {8{m_inv}};
            m_valid = 1'b1;
          end
        end else if (w == (SYNC ^ {8{m_inv}})) begin
          if (!m_locked) begin
            m_good++;
            if (m_good >= int'(LOCK)) begin
              m_locked = 1'b1;
              m_bad    = 0;
            end
          end else begin
            m_bad = 0;
          end
        end else begin
          m_err = 1'b1;
          if (!m_locked) model_drop();
          else begin
            m_bad++;
            if (m_bad >= int'(MISS)) model_drop();
          end
        end
      end
    end
  endtask

  task automatic step(input logic d, input logic en);
    @(negedge CLK);
    Din    = d;
    bit_en = en;
    @(posedge CLK);
    if (en) model_bit(d);
    else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end
    #1;
    check_eq("dout", 32'(dout), 32'(m_dout));
    check_eq("dout_valid", 32'(dout_valid), 32'(m_valid));
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("sync_err", 32'(sync_err), 32'(m_err));
    check_eq("inverted", 32'(inverted), 32'(m_inv));
    if (en) n_bits++;
    if (en && locked && lock_bit < 0) lock_bit = n_bits;
    if (dout_valid) n_valid++;
    if (sync_err) n_err++;
    if (locked) n_lock_cyc++;
  endtask

  task automatic send_word(input logic [7:0] w, input int idle_pct);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++)
        if (int'($urandom_range(99)) < idle_pct) step(1'($urandom_range(1)), 1'b0);
      step(w[i], 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; Din = 1'b0; bit_en = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_dout"}, 32'(dout), 32'h0);
    check_eq({tag, "_valid"}, 32'(dout_valid), 32'h0);
    check_eq({tag, "_locked"}, 32'(locked), 32'h0);
    check_eq({tag, "_err"}, 32'(sync_err), 32'h0);
    check_eq({tag, "_inv"}, 32'(inverted), 32'h0);
  endtask

  initial begin
    logic [7:0] c;
    RST = 1'b0; Din = 1'b0; bit_en = 1'b0;
    model_reset();
    // Asynchronous reset before any clock edge
    #2 RST = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge CLK);
    RST = 1'b0;

    // Clean aligned sync/payload stream
    repeat (12) send_word(SYNC, 0);
    check_eq("t1_lock_latency", 32'(lock_bit), 32'd40);
    check_eq("t1_valid_count", 32'(n_valid), 32'd4);
    check_eq("t1_no_err", 32'(n_err), 32'd0);
    check_eq("t1_dout", 32'(dout), 32'h78);

    // One corrupted sync slot, then two close together
    n_err = 0;
    send_word(8'h79, 0); send_word(SYNC, 0); send_word(SYNC, 0); send_word(SYNC, 0);
    check_eq("t3_single_err", 32'(n_err), 32'd1);
    check_eq("t3_still_locked", 32'(locked), 32'd1);
    send_word(8'h70, 0); send_word(SYNC, 0);
    c = 8'h70;
    for (int i = 0; i < 7; i++) step(c[i], 1'b1);
    check_eq("t3_locked_before_last", 32'(locked), 32'd1);
    step(c[7], 1'b1);
    check_eq("t3_drop", 32'(locked), 32'd0);
    check_eq("t3_err_pulse", 32'(sync_err), 32'd1);

    // Constant zero stream
    do_reset();
    repeat (200) step(1'b0, 1'b1);
    check_eq("t2_never_locked", 32'(n_lock_cyc), 32'd0);
    check_eq("t2_no_valid", 32'(n_valid), 32'd0);
    check_eq("t2_no_err", 32'(n_err), 32'd0);

    // Same clean stream with bit_en gaps
    do_reset();
    repeat (12) send_word(SYNC, 40);
    check_eq("t4_lock_latency", 32'(lock_bit), 32'd40);
    check_eq("t4_valid_count", 32'(n_valid), 32'd4);
    check_eq("t4_no_err", 32'(n_err), 32'd0);

    // Reset in the middle of a payload word while locked
    do_reset();
    repeat (7) send_word(SYNC, 0);
    c = SYNC;
    for (int i = 0; i < 3; i++) step(c[i], 1'b1);
    check_eq("t5_pre_locked", 32'(locked), 32'd1);
    check_eq("t5_pre_dout", 32'(dout), 32'h78);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1 check_reset_outputs("t5_async");
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    repeat (12) send_word(SYNC, 0);
    check_eq("t5_relock_latency", 32'(lock_bit), 32'd40);

    // Inverted sync word with a non-symmetric payload
    do_reset();
    repeat (6) begin
      send_word(8'h87, 0);
      send_word(8'h5A, 0);
    end
    if (PolEn) begin
      check_eq("t6_locked", 32'(locked), 32'd1);
      check_eq("t6_inverted", 32'(inverted), 32'd1);
      check_eq("t6_dout", 32'(dout), 32'hA5);
    end else begin
      check_eq("t6_locked_cycles", 32'(n_lock_cyc), 32'd0);
      check_eq("t6_inverted", 32'(inverted), 32'd0);
    end

    // Random frames: mostly-good sync words, random payload, slips and bit_en gaps
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(39) == 0) step(1'($urandom_range(1)), 1'b1);
      if (k % 2 == 0) send_word(($urandom_range(9) < 8) ? SYNC : 8'($urandom), 20);
      else            send_word(8'($urandom), 20);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
